// File: rtl/matrix_ram_arbiter_if.sv
// Bus bundle between the two RAM requesters (CU = port 0, host = port 1),
// the matrix RAM and the matrix_ram_arbiter.
interface matrix_ram_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
);
  logic              req0;
  logic              lock0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              gnt0;
  logic              rvalid0;
  logic [DATA_W-1:0] rdata0;

  logic              req1;
  logic              lock1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              gnt1;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata1;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_w_data;
  logic [DATA_W-1:0] ram_r_data;
  logic              hold_break;

  // Requesters plus the RAM itself.
  modport master (
    output req0, lock0, we0, addr0, wdata0,
    output req1, lock1, we1, addr1, wdata1,
    input  gnt0, rvalid0, rdata0,
    input  gnt1, rvalid1, rdata1,
    input  ram_we, ram_addr, ram_w_data, hold_break,
    output ram_r_data
  );

  modport slave (
    input  req0, lock0, we0, addr0, wdata0,
    input  req1, lock1, we1, addr1, wdata1,
    output gnt0, rvalid0, rdata0,
    output gnt1, rvalid1, rdata1,
    output ram_we, ram_addr, ram_w_data, hold_break,
    input  ram_r_data
  );
endinterface

// File: rtl/matrix_ram_arbiter.sv
// Two-port arbiter for the single-port matrix RAM: round-robin grant, bounded lock
// hold, read-data routing. Define ARB_STATS_EN for conflict/break statistics counters.
module matrix_ram_arbiter #(
  parameter int DATA_W   = 32,
  parameter int RAM_D    = 512,
  parameter int ADDR_W   = $clog2(RAM_D),
  parameter int MAX_HOLD = 16
) (
  input  logic                clk,
  input  logic                rst,
  matrix_ram_arbiter_if.slave bus
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]         conflict_cnt_o,
  output logic [7:0]          break_cnt_o
`endif
);

  // state | meaning
  // IDLE  | no grant
  // OWN0  | CU owns the RAM port (gnt0)
  // OWN1  | host owns the RAM port (gnt1)
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t            state_q;
  logic [7:0]        hold_q;
  logic              last_q;
  logic              brk_q;
  logic              rv0_q, rv1_q;
  logic [DATA_W-1:0] rd0_q, rd1_q;
  logic [ADDR_W-1:0] addr_q;

  logic   req0, req1, own1, lock_own, req_own, req_oth;
  logic   acc0, acc1;
  state_t oth_state;

  assign req0      = bus.req0;
  assign req1      = bus.req1;
  assign own1      = (state_q == OWN1);
  assign lock_own  = own1 ? bus.lock1 : bus.lock0;
  assign req_own   = own1 ? req1 : req0;
  assign req_oth   = own1 ? req0 : req1;
  assign oth_state = own1 ? OWN0 : OWN1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      last_q  <= 1'b1;
      brk_q   <= 1'b0;
    end else begin
      brk_q <= 1'b0;
      case (state_q)
        IDLE: begin
          hold_q <= '0;
          if (req0 && req1) begin
            state_q <= last_q ? OWN0 : OWN1;
            last_q  <= ~last_q;
          end else if (req0) begin
            state_q <= OWN0;
            last_q  <= 1'b0;
          end else if (req1) begin
            state_q <= OWN1;
            last_q  <= 1'b1;
          end
        end
        default: begin
          // A contested lock is honoured for MAX_HOLD owner cycles, then broken.
          if (lock_own && req_oth) begin
            if (hold_q == HOLD_LAST) begin
              state_q <= oth_state;
              last_q  <= ~own1;
              brk_q   <= 1'b1;
              hold_q  <= '0;
            end else begin
              hold_q <= hold_q + 8'd1;
            end
          end else begin
            hold_q <= '0;
            if (!lock_own) begin
              if (req_oth) begin
                state_q <= oth_state;
                last_q  <= ~own1;
              end else if (!req_own) begin
                state_q <= IDLE;
              end
            end
          end
        end
      endcase
    end
  end

  assign bus.gnt0       = (state_q == OWN0);
  assign bus.gnt1       = (state_q == OWN1);
  assign bus.hold_break = brk_q;

  assign acc0 = bus.gnt0 & req0;
  assign acc1 = bus.gnt1 & req1;

  assign bus.ram_we     = (acc0 & bus.we0) | (acc1 & bus.we1);
  assign bus.ram_addr   = acc0 ? bus.addr0 : (acc1 ? bus.addr1 : addr_q);
  assign bus.ram_w_data = bus.gnt1 ? bus.wdata1 : bus.wdata0;

  // Read tags are independent of the grant so data returns after an ownership switch.
  always_ff @(posedge clk) begin
    if (rst) begin
      rv0_q  <= 1'b0;
      rv1_q  <= 1'b0;
      rd0_q  <= '0;
      rd1_q  <= '0;
      addr_q <= '0;
    end else begin
      rv0_q <= acc0 & ~bus.we0;
      rv1_q <= acc1 & ~bus.we1;
      if (acc0 | acc1) addr_q <= bus.ram_addr;
      if (rv0_q) rd0_q <= bus.ram_r_data;
      if (rv1_q) rd1_q <= bus.ram_r_data;
    end
  end

  assign bus.rvalid0 = rv0_q & ~rst;
  assign bus.rvalid1 = rv1_q & ~rst;
  assign bus.rdata0  = rv0_q ? bus.ram_r_data : rd0_q;
  assign bus.rdata1  = rv1_q ? bus.ram_r_data : rd1_q;

`ifdef ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt_o <= '0;
      break_cnt_o    <= '0;
    end else begin
      if (req0 && req1 && conflict_cnt_o != 16'hFFFF) conflict_cnt_o <= conflict_cnt_o + 16'd1;
      if (brk_q && break_cnt_o != 8'hFF) break_cnt_o <= break_cnt_o + 8'd1;
    end
  end
`endif

  a_one_grant: assert property (@(posedge clk) disable iff (rst) !(bus.gnt0 && bus.gnt1));
  a_we_grant:  assert property (@(posedge clk) disable iff (rst) bus.ram_we |-> (bus.gnt0 ^ bus.gnt1));

endmodule

// File: tb/tb_matrix_ram_arbiter.sv
// Randomized + directed bench for matrix_ram_arbiter against a cycle-level
// ownership/memory reference model.
module tb_matrix_ram_arbiter;
  localparam int DW = 32;
  localparam int AW = 9;
  localparam int RD = 512;
  localparam int MH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  matrix_ram_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus();

`ifdef ARB_STATS_EN
  logic [15:0] conflict_cnt;
  logic [7:0]  break_cnt;
`endif

  matrix_ram_arbiter #(.DATA_W(DW), .RAM_D(RD), .MAX_HOLD(MH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ARB_STATS_EN
    ,
    .conflict_cnt_o (conflict_cnt),
    .break_cnt_o    (break_cnt)
`endif
  );

  // Environment RAM: 1-cycle read latency.
  logic [DW-1:0] mem [RD];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_w_data;
    bus.ram_r_data <= mem[bus.ram_addr];
  end

  int nvec = 0;
  int nerr = 0;

  // Reference model: who owns the port, who won last, how long a contested lock has run.
  int          m_own   = -1;
  int          m_last  = 1;
  int          m_run   = 0;
  bit          m_brk   = 1'b0;
  bit          m_rv  [2];
  bit          m_rvk [2];
  logic [31:0] m_rvd [2];
  logic [31:0] ref_mem [RD];
  bit          ref_vld [RD];
  int          m_ccnt  = 0;
  int          m_bcnt  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input bit r0, input bit l0, input bit w0, input int a0, input logic [31:0] d0,
                     input bit r1, input bit l1, input bit w1, input int a1, input logic [31:0] d1,
                     input bit rs);
    bit          rq [2];
    bit          lk [2];
    bit          we [2];
    int          ad [2];
    logic [31:0] wd [2];
    bit          nrv [2];
    bit          acc;
    int          nxt;
    int          oth;
    logic [31:0] rv_got [2];
    logic [31:0] rd_got [2];
    @(negedge clk);
    bus.req0 = r0; bus.lock0 = l0; bus.we0 = w0; bus.addr0 = a0[AW-1:0]; bus.wdata0 = d0;
    bus.req1 = r1; bus.lock1 = l1; bus.we1 = w1; bus.addr1 = a1[AW-1:0]; bus.wdata1 = d1;
    rst = rs;
    rq[0] = r0; lk[0] = l0; we[0] = w0; ad[0] = a0; wd[0] = d0;
    rq[1] = r1; lk[1] = l1; we[1] = w1; ad[1] = a1; wd[1] = d1;
    #1;
    acc = 1'b0;
    if (m_own >= 0) acc = rq[m_own];
    chk("gnt0", 32'(bus.gnt0), 32'(m_own == 0));
    chk("gnt1", 32'(bus.gnt1), 32'(m_own == 1));
    chk("hold_break", 32'(bus.hold_break), 32'(m_brk));
    chk("ram_we", 32'(bus.ram_we), 32'(acc && we[m_own < 0 ? 0 : m_own]));
    if (acc) chk("ram_addr", 32'(bus.ram_addr), 32'(ad[m_own]));
    if (acc && we[m_own]) chk("ram_w_data", bus.ram_w_data, wd[m_own]);
    rv_got[0] = 32'(bus.rvalid0); rv_got[1] = 32'(bus.rvalid1);
    rd_got[0] = bus.rdata0;       rd_got[1] = bus.rdata1;
    for (int x = 0; x < 2; x++) begin
      chk($sformatf("rvalid%0d", x), rv_got[x], 32'(m_rv[x] && !rs));
      if (m_rv[x] && !rs && m_rvk[x]) chk($sformatf("rdata%0d", x), rd_got[x], m_rvd[x]);
    end
`ifdef ARB_STATS_EN
    chk("conflict_cnt", 32'(conflict_cnt), 32'(m_ccnt));
    chk("break_cnt", 32'(break_cnt), 32'(m_bcnt));
`endif
    // Advance the model across the coming clock edge.
    if (!rs) begin
      if (r0 && r1 && m_ccnt < 65535) m_ccnt++;
      if (m_brk && m_bcnt < 255) m_bcnt++;
    end
    for (int x = 0; x < 2; x++) begin
      nrv[x] = !rs && acc && (m_own == x) && !we[x];
      if (nrv[x]) begin
        m_rvd[x] = ref_mem[ad[x]];
        m_rvk[x] = ref_vld[ad[x]];
      end
    end
    if (acc && we[m_own]) begin
      ref_mem[ad[m_own]] = wd[m_own];
      ref_vld[ad[m_own]] = 1'b1;
    end
    if (rs) begin
      m_own = -1; m_last = 1; m_run = 0; m_brk = 1'b0;
      m_rv[0] = 1'b0; m_rv[1] = 1'b0;
      m_ccnt = 0; m_bcnt = 0;
    end else begin
      m_brk = 1'b0;
      nxt = m_own;
      if (m_own < 0) begin
        m_run = 0;
        if (r0 && r1) nxt = 1 - m_last;
        else if (r0)  nxt = 0;
        else if (r1)  nxt = 1;
      end else begin
        oth = 1 - m_own;
        if (lk[m_own] && rq[oth]) begin
          m_run++;
          if (m_run == MH) begin
            nxt = oth; m_brk = 1'b1; m_run = 0;
          end
        end else begin
          m_run = 0;
          if (!lk[m_own]) begin
            if (rq[oth])           nxt = oth;
            else if (!rq[m_own])   nxt = -1;
          end
        end
      end
      if (nxt >= 0 && nxt != m_own) m_last = nxt;
      m_own = nxt;
      m_rv[0] = nrv[0]; m_rv[1] = nrv[1];
    end
  endtask

  task automatic idle_cyc(input bit rs);
    cyc(0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, rs);
  endtask

  int cu_cycles, brk_first, brk_total;
  bit seen1;
  int p0, p1, pl0, pl1;

  initial begin
    bus.req0 = 0; bus.lock0 = 0; bus.we0 = 0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 0; bus.lock1 = 0; bus.we1 = 0; bus.addr1 = '0; bus.wdata1 = '0;
    rst = 1'b1;

    // Reset state and host-only write/readback.
    idle_cyc(1);
    idle_cyc(0);
    cyc(0, 0, 0, 0, 0, 1, 0, 1, 5, 32'hDEADBEEF, 0);
    chk("host_gnt_wait", 32'(bus.gnt1), 32'd0);
    cyc(0, 0, 0, 0, 0, 1, 0, 1, 5, 32'hDEADBEEF, 0);
    chk("host_gnt", 32'(bus.gnt1), 32'd1);
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 5, 32'h0, 0);
    idle_cyc(0);
    chk("host_rvalid", 32'(bus.rvalid1), 32'd1);
    chk("host_rdata", bus.rdata1, 32'hDEADBEEF);
    chk("host_no_gnt0", 32'(bus.gnt0), 32'd0);
    idle_cyc(0);

    // Simultaneous requests from reset, no locks: 0,1,0,1...
    idle_cyc(1);
    for (int i = 0; i < 7; i++) begin
      cyc(1, 0, 0, i, $urandom, 1, 0, 0, i + 8, $urandom, 0);
      if (i >= 1) chk("alt_gnt0", 32'(bus.gnt0), 32'(i % 2 == 1));
    end

    // CU lock vs continuous host requests.
    idle_cyc(1);
    cu_cycles = 0; brk_first = 0; brk_total = 0; seen1 = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1, 1, 0, $urandom_range(0, 15), 32'h0, 1, 0, 0, $urandom_range(0, 15), 32'h0, 0);
      if (bus.hold_break) brk_total++;
      if (!seen1) begin
        if (bus.gnt0) cu_cycles++;
        if (bus.hold_break) brk_first++;
        if (bus.gnt1) seen1 = 1;
      end
    end
    chk("lock_cu_cycles", 32'(cu_cycles), 32'd16);
    chk("lock_break_first", 32'(brk_first), 32'd1);
    chk("lock_break_total", 32'(brk_total), 32'd2);
`ifdef ARB_STATS_EN
    chk("stats_break_cnt", 32'(break_cnt), 32'd2);
    idle_cyc(1);
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 1, 32'h0, 1, 0, 0, 2, 32'h0, 0);
    idle_cyc(0);
    chk("stats_conflict_cnt", 32'(conflict_cnt), 32'd10);
`endif

    // CU read followed by a grant switch to the host.
    idle_cyc(1);
    cyc(1, 0, 1, 100, 32'h12345678, 0, 0, 0, 0, 32'h0, 0);
    cyc(1, 0, 1, 100, 32'h12345678, 0, 0, 0, 0, 32'h0, 0);
    cyc(1, 0, 0, 100, 32'h0, 1, 0, 0, 7, 32'h0, 0);
    cyc(0, 0, 0, 0, 32'h0, 1, 0, 0, 7, 32'h0, 0);
    chk("sw_gnt1", 32'(bus.gnt1), 32'd1);
    chk("sw_rvalid0", 32'(bus.rvalid0), 32'd1);
    chk("sw_rdata0", bus.rdata0, 32'h12345678);
    chk("sw_rvalid1", 32'(bus.rvalid1), 32'd0);
    idle_cyc(0);

    // Reset right after a read access.
    idle_cyc(1);
    cyc(0, 0, 0, 0, 32'h0, 1, 0, 0, 5, 32'h0, 0);
    cyc(0, 0, 0, 0, 32'h0, 1, 0, 0, 5, 32'h0, 0);
    idle_cyc(1);
    chk("rst_rvalid1", 32'(bus.rvalid1), 32'd0);
    idle_cyc(0);
    chk("rst_gnt0", 32'(bus.gnt0), 32'd0);
    chk("rst_gnt1", 32'(bus.gnt1), 32'd0);
    chk("rst_rvalid1_after", 32'(bus.rvalid1), 32'd0);

    // Randomized traffic in phases with varying request and lock pressure.
    p0 = 50; p1 = 50; pl0 = 0; pl1 = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 100 == 0) begin
        p0  = $urandom_range(10, 100);
        p1  = $urandom_range(10, 100);
        pl0 = ($urandom_range(0, 2) == 0) ? 95 : $urandom_range(0, 40);
        pl1 = ($urandom_range(0, 2) == 0) ? 95 : $urandom_range(0, 40);
      end
      cyc($urandom_range(0, 99) < p0, $urandom_range(0, 99) < pl0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 15), $urandom,
          $urandom_range(0, 99) < p1, $urandom_range(0, 99) < pl1, $urandom_range(0, 1) == 1,
          $urandom_range(0, 15), $urandom,
          $urandom_range(0, 499) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
